mode_reporter: RTL and testbench

- Serial status transmitter for the arm controller.
- Watches the 2-bit mode state from the switch-decoding FSM.
- Whenever the reported mode differs from the current mode, it sends a fixed 4-byte ASCII message over a UART TX line (8N1, LSB first) so a host terminal can track the control mode.
- Sits downstream of the mode FSM and drives the board's UART TX pin.

---
 rtl/arm_pkg.sv | 29 ++
 rtl/uart_tx_byte.sv | 59 +++++
 rtl/mode_reporter.sv | 114 +++++++++++
 tb/tb_mode_reporter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared arm-controller mode encoding and ASCII report characters
package arm_pkg;

    typedef enum logic [1:0] {
        MODE_SELECT     = 2'b00,
        MODE_ULTRASONIC = 2'b01,
        MODE_KEYBOARD   = 2'b10,
        MODE_ANALOG     = 2'b11
    } mode_t;

    localparam logic [7:0] CHAR_M  = 8'h4D;
    localparam logic [7:0] CHAR_S  = 8'h53;
    localparam logic [7:0] CHAR_U  = 8'h55;
    localparam logic [7:0] CHAR_K  = 8'h4B;
    localparam logic [7:0] CHAR_A  = 8'h41;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Character that names a control mode in the serial status report.
    function automatic logic [7:0] mode_char(input mode_t mode);
        case (mode)
            MODE_SELECT:     mode_char = CHAR_S;
            MODE_ULTRASONIC: mode_char = CHAR_U;
            MODE_KEYBOARD:   mode_char = CHAR_K;
            default:         mode_char = CHAR_A;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first UART byte serialiser
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    localparam logic [9:0] LAST_CNT = 10'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX = 4'd9;

    logic       active;
    logic [9:0] bit_cnt;
    logic [3:0] bit_idx;
    logic [7:0] data_q;
    logic       bit_end;
    logic       load;

    // done marks the final cycle of the stop bit; a start accepted then
    // begins the next start bit on the very next edge, leaving no idle gap.
    assign bit_end = active && (bit_cnt == LAST_CNT);
    assign done    = bit_end && (bit_idx == STOP_IDX);
    assign ready   = !active || done;
    assign load    = start && ready;

    // Bit timing and registered serial output; tx only moves at bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            data_q  <= data;
            tx      <= 1'b0;
        end else if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
                active  <= 1'b0;
                bit_idx <= '0;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= (bit_idx == 4'd8) ? 1'b1 : data_q[bit_idx[2:0]];
            end
        end else if (active) begin
            bit_cnt <= bit_cnt + 10'd1;
        end
    end

endmodule

// File: rtl/mode_reporter.sv
// rtl/mode_reporter.sv - reports control-mode changes as "M<mode>\r\n" over UART
import arm_pkg::*;

module mode_reporter #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic       tx,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0] fsm;
    logic [0:0] fsm_next;
    mode_t      last_sent;
    mode_t      snapshot;
    logic       sent_valid;
    logic [1:0] byte_idx;
    logic [1:0] idx_next;
    logic       need_msg;
    logic       launch;
    logic       start;
    logic       ready;
    logic       done;
    logic [7:0] tx_data;

    // The live mode is compared only when no message is in flight, so
    // intermediate modes seen mid-message collapse into at most one follow-up.
    assign need_msg = !sent_valid || (mode_t'(state) != last_sent);
    assign busy     = (fsm == ST_SEND);

    // Controller: launch a message, step through its bytes, chain a follow-up
    // straight off the last stop bit when the mode moved meanwhile.
    always_comb begin
        fsm_next = fsm;
        idx_next = byte_idx;
        launch   = 1'b0;
        start    = 1'b0;
        case (fsm)
            ST_IDLE: begin
                if (need_msg && ready) begin
                    launch   = 1'b1;
                    start    = 1'b1;
                    idx_next = 2'd0;
                    fsm_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (done) begin
                    if (byte_idx == 2'd3) begin
                        if (need_msg) begin
                            launch   = 1'b1;
                            start    = 1'b1;
                            idx_next = 2'd0;
                        end else begin
                            fsm_next = ST_IDLE;
                        end
                    end else begin
                        start    = 1'b1;
                        idx_next = byte_idx + 2'd1;
                    end
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    // Byte mux for the byte being started; index 0 is constant so a fresh
    // launch does not depend on the snapshot being written at the same edge.
    always_comb begin
        case (idx_next)
            2'd0:    tx_data = CHAR_M;
            2'd1:    tx_data = mode_char(snapshot);
            2'd2:    tx_data = CHAR_CR;
            default: tx_data = CHAR_LF;
        endcase
    end

    // Controller state and the mode bookkeeping captured at message launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm        <= ST_IDLE;
            sent_valid <= 1'b0;
            last_sent  <= MODE_SELECT;
            snapshot   <= MODE_SELECT;
            byte_idx   <= 2'd0;
        end else begin
            fsm      <= fsm_next;
            byte_idx <= idx_next;
            if (launch) begin
                snapshot   <= mode_t'(state);
                last_sent  <= mode_t'(state);
                sent_valid <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (tx_data),
        .ready (ready),
        .done  (done),
        .tx    (tx)
    );

endmodule

// File: tb/tb_mode_reporter.sv
// tb/tb_mode_reporter.sv - self-checking bench for mode_reporter
module tb_mode_reporter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state = 2'b00;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    mode_reporter #(.CLKS_PER_BIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a message is 160 cycles of line levels; whenever no
    // message is in progress and the mode differs from the last one reported
    // (or nothing was reported since reset), a new message begins at this edge.
    bit         m_active = 1'b0;
    bit         m_valid  = 1'b0;
    int         m_pos    = 0;
    logic [1:0] m_last   = 2'b00;
    logic [1:0] m_mode   = 2'b00;
    logic       exp_tx   = 1'b1;
    logic       exp_busy = 1'b0;

    function automatic logic [7:0] char_of(input logic [1:0] m);
        case (m)
            2'd0:    return 8'h53;
            2'd1:    return 8'h55;
            2'd2:    return 8'h4B;
            default: return 8'h41;
        endcase
    endfunction

    function automatic logic level_at(input int p, input logic [1:0] m);
        logic [7:0] b;
        int         bit_n;
        case (p / 40)
            0:       b = 8'h4D;
            1:       b = char_of(m);
            2:       b = 8'h0D;
            default: b = 8'h0A;
        endcase
        bit_n = (p % 40) / 4;
        if (bit_n == 0) return 1'b0;
        if (bit_n == 9) return 1'b1;
        return b[bit_n - 1];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
        end else begin
            if (m_active) begin
                m_pos++;
                if (m_pos == 160) m_active = 1'b0;
            end
            if (!m_active && (!m_valid || state != m_last)) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_last   = state;
                m_mode   = state;
                m_valid  = 1'b1;
            end
        end
        exp_tx   = m_active ? level_at(m_pos, m_mode) : 1'b1;
        exp_busy = m_active;
    end

    // UART receiver: samples mid-bit and queues each byte with a good stop bit.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    bit         rx_on = 1'b0;
    int         rx_t  = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t >= 6 && rx_t <= 34 && (rx_t % 4) == 2) rx_sh[(rx_t - 6) / 4] = tx;
            if (rx_t == 38 && tx === 1'b1) rx_q.push_back(rx_sh);
            if (rx_t == 39) rx_on = 1'b0;
        end
    end

    task automatic test_reset();
        int         busy_cnt = 0;
        logic [7:0] exp_b[$];
        reset = 1'b1;
        state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
            end
        end
        reset = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_start_bit: tx=%b, expected 0", tx);
                end
            end
            n_checks++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL reset_run cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         i, tx, busy, exp_tx, exp_busy);
            end
            if (busy === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 160) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles, expected 160", busy_cnt);
        end
        exp_b = '{8'h4D, 8'h53, 8'h0D, 8'h0A};
        n_checks++;
        if (rx_q.size() != exp_b.size()) begin
            n_fail++;
            $display("FAIL reset_bytes count: got %0d, expected %0d", rx_q.size(), exp_b.size());
        end
        foreach (exp_b[k]) if (k < rx_q.size()) begin
            n_checks++;
            if (rx_q[k] !== exp_b[k]) begin
                n_fail++;
                $display("FAIL reset_bytes[%0d]: got %h, expected %h", k, rx_q[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_mode_change();
        logic [1:0] a;
        logic [7:0] exp_b[$];
        for (int r = 0; r < 3; r++) begin
            a = m_last + 2'($urandom_range(1, 3));
            rx_q.delete();
            state = a;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    n_checks++;
                    if (tx !== 1'b0 || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL change_latency: tx=%b busy=%b, expected tx=0 busy=1", tx, busy);
                    end
                end
                n_checks++;
                if (tx !== exp_tx || busy !== exp_busy) begin
                    n_fail++;
                    $display("FAIL change_run cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                             i, tx, busy, exp_tx, exp_busy);
                end
            end
            exp_b = '{8'h4D, char_of(a), 8'h0D, 8'h0A};
            n_checks++;
            if (rx_q.size() != exp_b.size()) begin
                n_fail++;
                $display("FAIL change_bytes count: got %0d, expected %0d", rx_q.size(), exp_b.size());
            end
            foreach (exp_b[k]) if (k < rx_q.size()) begin
                n_checks++;
                if (rx_q[k] !== exp_b[k]) begin
                    n_fail++;
                    $display("FAIL change_bytes[%0d]: got %h, expected %h", k, rx_q[k], exp_b[k]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] a;
        logic [1:0] b;
        int         busy_cnt = 0;
        logic [7:0] exp_b[$];
        a = m_last + 2'($urandom_range(1, 3));
        b = a + 2'($urandom_range(1, 3));
        rx_q.delete();
        state = a;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL glitch_run cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         i, tx, busy, exp_tx, exp_busy);
            end
            if (busy === 1'b1) busy_cnt++;
            if (i == 50) state = b;
            if (i == 120) state = a;
        end
        n_checks++;
        if (busy_cnt != 160) begin
            n_fail++;
            $display("FAIL glitch_busy_len: got %0d cycles, expected 160", busy_cnt);
        end
        exp_b = '{8'h4D, char_of(a), 8'h0D, 8'h0A};
        n_checks++;
        if (rx_q.size() != exp_b.size()) begin
            n_fail++;
            $display("FAIL glitch_bytes count: got %0d, expected %0d", rx_q.size(), exp_b.size());
        end
        foreach (exp_b[k]) if (k < rx_q.size()) begin
            n_checks++;
            if (rx_q[k] !== exp_b[k]) begin
                n_fail++;
                $display("FAIL glitch_bytes[%0d]: got %h, expected %h", k, rx_q[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        int         busy_cnt = 0;
        logic [7:0] exp_b[$];
        a = m_last + 2'($urandom_range(1, 3));
        b = a + 2'($urandom_range(1, 3));
        c = a + 2'($urandom_range(1, 3));
        rx_q.delete();
        state = a;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b_run cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         i, tx, busy, exp_tx, exp_busy);
            end
            if (busy === 1'b1) busy_cnt++;
            if (i == 50) state = b;
            if (i == 100) state = c;
        end
        n_checks++;
        if (busy_cnt != 320) begin
            n_fail++;
            $display("FAIL b2b_busy_len: got %0d cycles, expected 320", busy_cnt);
        end
        exp_b = '{8'h4D, char_of(a), 8'h0D, 8'h0A, 8'h4D, char_of(c), 8'h0D, 8'h0A};
        n_checks++;
        if (rx_q.size() != exp_b.size()) begin
            n_fail++;
            $display("FAIL b2b_bytes count: got %0d, expected %0d", rx_q.size(), exp_b.size());
        end
        foreach (exp_b[k]) if (k < rx_q.size()) begin
            n_checks++;
            if (rx_q[k] !== exp_b[k]) begin
                n_fail++;
                $display("FAIL b2b_bytes[%0d]: got %h, expected %h", k, rx_q[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] a;
        logic [1:0] d;
        logic [7:0] exp_b[$];
        a = m_last + 2'($urandom_range(1, 3));
        d = 2'($urandom_range(0, 3));
        state = a;
        for (int i = 0; i < 86; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL midreset_pre cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         i, tx, busy, exp_tx, exp_busy);
            end
        end
        reset = 1'b1;
        state = d;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_abort: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
        end
        reset = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== exp_tx || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL midreset_post cycle %0d: tx=%b busy=%b, expected tx=%b busy=%b",
                         i, tx, busy, exp_tx, exp_busy);
            end
        end
        exp_b = '{8'h4D, char_of(d), 8'h0D, 8'h0A};
        n_checks++;
        if (rx_q.size() != exp_b.size()) begin
            n_fail++;
            $display("FAIL midreset_bytes count: got %0d, expected %0d", rx_q.size(), exp_b.size());
        end
        foreach (exp_b[k]) if (k < rx_q.size()) begin
            n_checks++;
            if (rx_q[k] !== exp_b[k]) begin
                n_fail++;
                $display("FAIL midreset_bytes[%0d]: got %h, expected %h", k, rx_q[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_hold();
        rx_q.delete();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || exp_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: tx=%b busy=%b, expected tx=1 busy=0", i, tx, busy);
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_bytes: got %0d bytes, expected 0", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
